// File: rtl/signalio_arbiter.sv
// Two-requester round-robin arbiter in front of a single PIO slave register.
// Outputs are registered from the next-state decode, so they line up with the state they belong to.
module signalio_arbiter #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ack,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ack,
    output logic [DW-1:0] rsp_data,
    output logic [1:0]    pio_address,
    output logic          pio_chipselect,
    output logic          pio_write_n,
    output logic [31:0]   pio_writedata,
    input  logic [31:0]   pio_readdata
);

    typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_CAP} state_t;

    state_t        state, state_nxt;
    logic          ptr, ptr_nxt;
    logic          gnt_id, gnt_id_nxt;
    logic          winner;
    logic [DW-1:0] wdata_sel;
    logic          unused_readdata;

    assign pio_address     = '0;
    assign unused_readdata = ^pio_readdata;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_id_nxt = gnt_id;
        winner     = (req0_valid && req1_valid) ? ptr : req1_valid;
        wdata_sel  = winner ? req1_wdata : req0_wdata;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_id_nxt = winner;
                    ptr_nxt    = ~winner;
                    state_nxt  = (winner ? req1_we : req0_we) ? WR : RD_ADDR;
                end
            end
            WR:      state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_CAP;
            RD_CAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is captured on the edge that enters RD_CAP so it is presented together with the ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            gnt_id         <= 1'b0;
            req0_ack       <= 1'b0;
            req1_ack       <= 1'b0;
            rsp_data       <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            gnt_id         <= gnt_id_nxt;
            pio_chipselect <= (state_nxt == WR) || (state_nxt == RD_ADDR);
            pio_write_n    <= (state_nxt != WR);
            req0_ack       <= ((state_nxt == WR) || (state_nxt == RD_CAP)) && !gnt_id_nxt;
            req1_ack       <= ((state_nxt == WR) || (state_nxt == RD_CAP)) && gnt_id_nxt;
            if (state_nxt == WR) begin
                pio_writedata <= 32'(wdata_sel);
            end
            if (state_nxt == RD_CAP) begin
                rsp_data <= pio_readdata[DW-1:0];
            end
        end
    end

endmodule
